// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, one-entry skid, stall and flush.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              ld_main, ld_skid, main_from_skid;
  logic              acc, xfer;

  assign ready_o = start_i & (state != SKID);
  assign valid_o = (state != EMPTY);
  assign ctrl_o  = valid_o ? main_ctrl : CTRL_BUBBLE;
  assign data_o  = main_data;

  assign acc  = valid_i & ready_o;
  assign xfer = valid_o & ready_i & ~stall_i & start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else if (start_i) begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_n = FULL;
            ld_main = 1'b1;
          end
        end
        FULL: begin
          if (acc && xfer) begin
            ld_main = 1'b1;
          end else if (acc) begin
            state_n = SKID;
            ld_skid = 1'b1;
          end else if (xfer) begin
            state_n = EMPTY;
          end
        end
        SKID: begin
          if (xfer) begin
            state_n        = FULL;
            ld_main        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ctrl <= CTRL_BUBBLE;
      main_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
    end else begin
      if (ld_main) begin
        main_ctrl <= main_from_skid ? skid_ctrl : ctrl_i;
        main_data <= main_from_skid ? skid_data : data_i;
      end
      if (ld_skid) begin
        skid_ctrl <= ctrl_i;
        skid_data <= data_i;
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  // Saturating; only reset clears them so flush keeps the history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (start_i && valid_o && (stall_i || !ready_i) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (start_i && !valid_o && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule
